vending_state_transitions: RTL and testbench
============================================

Name: vending_state_transitions

Overview:
Control core of the micro vending machine. It takes a goods selection (type and quantity) from switches, accumulates coins or notes, and on confirm or cancel pays out change one note per sys_Change press. All values are shown on an 8-digit multiplexed seven-segment display. It sits between the board-level input conditioning (switches and buttons) and the display pins.

Parameters:
SCAN_DIV, 100000, sys_clk cycles per display digit slot (1 ms at 100 MHz); the bench overrides it to a small value.

Ports:
sys_clk  in  1  system clock, 100 MHz, all logic on the rising edge
sys_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
sys_Goods  in  1  level button: start a selection
sys_Confirm  in  1  level button: confirm selection / confirm payment
sys_Change  in  1  level button: dispense one change note
sys_Cancel  in  1  level button: abort and refund
in_money_one/five/ten/twenty/fifty  in  1 each  level inputs: insert 1/5/10/20/50 yuan
type_SW_high  in  3  goods row, 0..7
type_SW_low  in  3  goods column, 0..7
num_SW  in  2  quantity, 0..3
Bit_select  out  8  digit enables, active-low one-hot, bit0 = rightmost digit
Seg_select  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}

Behaviour:
- Input conditioning: all buttons and money inputs are registered once. Only rising edges act (0->1 seen between consecutive clocks). A held level produces exactly one event.
- Reset: state=IDLE; unit_price, qty, total, paid, change_rem and last_note are all 0; scan counter and digit index are 0; Bit_select=8'hFF, Seg_select=8'hFF. Reset may occur in any state and takes effect immediately.
- Pricing: unit_price = 10*type_SW_high + type_SW_low (0..77). total = unit_price*num_SW (0..231). All values are 8-bit unsigned.
- States IDLE, SELECT, PAY, CHANGE; all transitions take 1 clock after the triggering edge.
- IDLE: a sys_Goods edge goes to SELECT. All other events are ignored.
- SELECT:
  - unit_price, qty and total track the switches every cycle.
  - A sys_Confirm edge with total!=0 latches them, clears paid and goes to PAY. With total==0 it stays in SELECT.
  - A sys_Cancel edge goes to IDLE.
- PAY:
  - Each money edge adds its value to paid. Edges on the same cycle are summed.
  - If paid+sum would exceed 255, the whole cycle's sum is rejected and paid is unchanged.
  - Confirm edge with paid>=total: change_rem=paid-total, go to CHANGE, or to IDLE if change_rem==0. Confirm with paid<total is ignored.
  - Cancel edge: change_rem=paid (refund), go to CHANGE, or to IDLE if paid==0.
  - Priority on the same cycle: Cancel > Confirm > money. Money edges are discarded on a Cancel or Confirm cycle.
- CHANGE:
  - Each sys_Change edge sets last_note to the largest of {50,20,10,5,1} that is <= change_rem, and subtracts it from change_rem.
  - When change_rem reaches 0, the next cycle goes to IDLE and clears paid, total and last_note.
  - Goods, Confirm, Cancel and money are ignored.
- Display scan:
  - The counter wraps at SCAN_DIV-1; each wrap advances the digit index 0->7->0.
  - Bit_select=~(1<<index) is registered, and Seg_select is the registered pattern for that digit (1-cycle latency, both change together).
  - After reset the first digit is shown after the first wrap; before that, all segments are blank.
- Digit content (digit7 leftmost, decimal values, leading zeros shown):
  - digit7 shows state code: 0 IDLE, 1 SELECT, 2 PAY, 3 CHANGE. digit6 is blank.
  - IDLE: digits5..0 show "-".
  - SELECT: d5=type_SW_high, d4=type_SW_low, d3=qty, d2..0=total.
  - PAY: d5..3=total, d2..0=paid.
  - CHANGE: d5..3=last_note, d2..0=change_rem.
- Segment codes: standard hex 0-9. Blank=8'hFF, "-"=8'hBF, dp is always off.
- Arithmetic: use combinational divide-by-10/100 or a lookup for the digits. Values never exceed 255.

Test Plan:
- Reset held 100 ns, then released -> Bit_select=FF, Seg_select=FF during reset; state IDLE; digit7 shows 0 and digits5..0 show "-" once scanning.
- Confirm in IDLE, then Goods edge; set high=2, low=1, num=3 -> state SELECT; total 63, display shows 2,1,3,063. Change high=3, low=3, num=1 -> total 33.
- From SELECT (33), Confirm edge -> PAY. Edges on one, five, ten, twenty -> paid 1, 6, 16, 36. A fifty edge is accepted -> 86.
- PAY total 33, paid 36, Confirm -> CHANGE with change_rem 3. Three Change edges -> last_note 1 each time, change_rem 2, 1, 0 -> IDLE. A fourth Change edge is ignored.
- PAY total 33, paid 70 (fifty+twenty), Cancel -> change 70. Change edges give 50, then 20 -> IDLE. Confirm and Cancel on the same edge -> Cancel wins.
- Overflow: paid 230, fifty edge -> paid stays 230. Async reset asserted mid-CHANGE -> immediately IDLE, all registers cleared.

Source files
------------

// File: rtl/vending_state_transitions.sv
// Vending machine control core: edge-detects buttons and money inputs,
// runs the IDLE/SELECT/PAY/CHANGE state machine and drives an 8-digit
// multiplexed seven-segment display (active-low digits and segments).
module vending_state_transitions #(
  parameter int SCAN_DIV = 100000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       sys_Goods,
  input  logic       sys_Confirm,
  input  logic       sys_Change,
  input  logic       sys_Cancel,
  input  logic       in_money_one,
  input  logic       in_money_five,
  input  logic       in_money_ten,
  input  logic       in_money_twenty,
  input  logic       in_money_fifty,
  input  logic [2:0] type_SW_high,
  input  logic [2:0] type_SW_low,
  input  logic [1:0] num_SW,
  output logic [7:0] Bit_select,
  output logic [7:0] Seg_select
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SELECT = 2'd1;
  localparam logic [1:0] ST_PAY    = 2'd2;
  localparam logic [1:0] ST_CHANGE = 2'd3;

  // Digit codes: 0..9 are numerals, the rest are symbols
  localparam logic [3:0] CODE_DASH  = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd11;

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // Event bit positions within the conditioned input vector
  localparam int EV_ONE     = 0;
  localparam int EV_FIVE    = 1;
  localparam int EV_TEN     = 2;
  localparam int EV_TWENTY  = 3;
  localparam int EV_FIFTY   = 4;
  localparam int EV_CANCEL  = 5;
  localparam int EV_CHANGE  = 6;
  localparam int EV_CONFIRM = 7;
  localparam int EV_GOODS   = 8;

  logic [8:0] raw_w;
  logic [8:0] in_q;
  logic [8:0] prev_q;
  logic [8:0] ev_w;

  logic [1:0] state_q, state_d;
  logic [7:0] price_q, price_d;
  logic [7:0] qty_q, qty_d;
  logic [7:0] total_q, total_d;
  logic [7:0] paid_q, paid_d;
  logic [7:0] change_q, change_d;
  logic [7:0] note_q, note_d;

  logic [7:0] price_w;
  logic [7:0] total_w;
  logic [8:0] money_sum_w;
  logic [8:0] paid_sum_w;
  logic [7:0] note_w;

  logic [CW-1:0] scan_cnt_q;
  logic [2:0]    digit_idx_q;
  logic          scan_on_q;
  logic          wrap_w;
  logic [7:0]    bit_sel_q;
  logic [7:0]    seg_q;
  logic [3:0]    code_w [8];

  function automatic logic [3:0] hundreds(input logic [7:0] v);
    return 4'(v / 8'd100);
  endfunction

  function automatic logic [3:0] tens(input logic [7:0] v);
    return 4'((v / 8'd10) % 8'd10);
  endfunction

  function automatic logic [3:0] ones(input logic [7:0] v);
    return 4'(v % 8'd10);
  endfunction

  function automatic logic [7:0] seg_of(input logic [3:0] c);
    logic [7:0] s;
    case (c)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      4'd10:   s = 8'hBF;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  assign raw_w = {sys_Goods, sys_Confirm, sys_Change, sys_Cancel,
                  in_money_fifty, in_money_twenty, in_money_ten,
                  in_money_five, in_money_one};

  // Register inputs once and keep the previous sample for edge detection
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      in_q   <= '0;
      prev_q <= '0;
    end else begin
      in_q   <= raw_w;
      prev_q <= in_q;
    end
  end

  assign ev_w = in_q & ~prev_q;

  assign price_w = ({5'd0, type_SW_high} * 8'd10) + {5'd0, type_SW_low};
  assign total_w = price_w * {6'd0, num_SW};

  assign money_sum_w = (ev_w[EV_ONE]    ? 9'd1  : 9'd0)
                     + (ev_w[EV_FIVE]   ? 9'd5  : 9'd0)
                     + (ev_w[EV_TEN]    ? 9'd10 : 9'd0)
                     + (ev_w[EV_TWENTY] ? 9'd20 : 9'd0)
                     + (ev_w[EV_FIFTY]  ? 9'd50 : 9'd0);
  assign paid_sum_w = {1'b0, paid_q} + money_sum_w;

  // Largest note that still fits in the remaining change
  always_comb begin
    if (change_q >= 8'd50)      note_w = 8'd50;
    else if (change_q >= 8'd20) note_w = 8'd20;
    else if (change_q >= 8'd10) note_w = 8'd10;
    else if (change_q >= 8'd5)  note_w = 8'd5;
    else if (change_q >= 8'd1)  note_w = 8'd1;
    else                        note_w = 8'd0;
  end

  // Next-state and datapath updates of the vending state machine
  always_comb begin
    state_d  = state_q;
    price_d  = price_q;
    qty_d    = qty_q;
    total_d  = total_q;
    paid_d   = paid_q;
    change_d = change_q;
    note_d   = note_q;
    case (state_q)
      ST_IDLE: begin
        if (ev_w[EV_GOODS]) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        price_d = price_w;
        qty_d   = {6'd0, num_SW};
        total_d = total_w;
        if (ev_w[EV_CANCEL]) begin
          state_d = ST_IDLE;
        end else if (ev_w[EV_CONFIRM] && (total_w != 8'd0)) begin
          paid_d  = 8'd0;
          state_d = ST_PAY;
        end
      end
      ST_PAY: begin
        if (ev_w[EV_CANCEL]) begin
          change_d = paid_q;
          state_d  = (paid_q == 8'd0) ? ST_IDLE : ST_CHANGE;
        end else if (ev_w[EV_CONFIRM]) begin
          if (paid_q >= total_q) begin
            change_d = paid_q - total_q;
            state_d  = (paid_q == total_q) ? ST_IDLE : ST_CHANGE;
          end
        end else if (!paid_sum_w[8]) begin
          // A cycle whose combined money would overflow is dropped whole
          paid_d = paid_sum_w[7:0];
        end
      end
      default: begin
        if (change_q == 8'd0) begin
          state_d = ST_IDLE;
          paid_d  = 8'd0;
          total_d = 8'd0;
          note_d  = 8'd0;
        end else if (ev_w[EV_CHANGE]) begin
          note_d   = note_w;
          change_d = change_q - note_w;
        end
      end
    endcase
  end

  // State machine and datapath registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      price_q  <= '0;
      qty_q    <= '0;
      total_q  <= '0;
      paid_q   <= '0;
      change_q <= '0;
      note_q   <= '0;
    end else begin
      state_q  <= state_d;
      price_q  <= price_d;
      qty_q    <= qty_d;
      total_q  <= total_d;
      paid_q   <= paid_d;
      change_q <= change_d;
      note_q   <= note_d;
    end
  end

  // Digit contents for the current state, digit 7 leftmost
  always_comb begin
    for (int i = 0; i < 8; i++) code_w[i] = CODE_BLANK;
    code_w[7] = {2'b00, state_q};
    case (state_q)
      ST_IDLE: begin
        for (int i = 0; i < 6; i++) code_w[i] = CODE_DASH;
      end
      ST_SELECT: begin
        code_w[5] = {1'b0, type_SW_high};
        code_w[4] = {1'b0, type_SW_low};
        code_w[3] = ones(qty_q);
        code_w[2] = hundreds(total_q);
        code_w[1] = tens(total_q);
        code_w[0] = ones(total_q);
      end
      ST_PAY: begin
        code_w[5] = hundreds(total_q);
        code_w[4] = tens(total_q);
        code_w[3] = ones(total_q);
        code_w[2] = hundreds(paid_q);
        code_w[1] = tens(paid_q);
        code_w[0] = ones(paid_q);
      end
      default: begin
        code_w[5] = hundreds(note_q);
        code_w[4] = tens(note_q);
        code_w[3] = ones(note_q);
        code_w[2] = hundreds(change_q);
        code_w[1] = tens(change_q);
        code_w[0] = ones(change_q);
      end
    endcase
  end

  assign wrap_w = (scan_cnt_q == CW'(SCAN_DIV - 1));

  // Scan timer and digit index; the display stays blank until the first wrap
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scan_cnt_q  <= '0;
      digit_idx_q <= '0;
      scan_on_q   <= 1'b0;
    end else if (wrap_w) begin
      scan_cnt_q  <= '0;
      digit_idx_q <= digit_idx_q + 3'd1;
      scan_on_q   <= 1'b1;
    end else begin
      scan_cnt_q  <= scan_cnt_q + CW'(1);
    end
  end

  // Registered digit enable and segment pattern, updated together
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bit_sel_q <= 8'hFF;
      seg_q     <= 8'hFF;
    end else if (scan_on_q) begin
      bit_sel_q <= ~(8'd1 << digit_idx_q);
      seg_q     <= seg_of(code_w[digit_idx_q]);
    end
  end

  assign Bit_select = bit_sel_q;
  assign Seg_select = seg_q;

endmodule

// File: tb/tb_vending_state_transitions.sv
// Directed bench for the vending control core: drives button/money edges
// and reads every value back from the scanned seven-segment display.
module tb_vending_state_transitions;

  localparam int SCAN = 4;

  // Press masks {goods, confirm, change, cancel, fifty, twenty, ten, five, one}
  localparam logic [8:0] P_GOODS   = 9'b1_0000_0000;
  localparam logic [8:0] P_CONFIRM = 9'b0_1000_0000;
  localparam logic [8:0] P_CHANGE  = 9'b0_0100_0000;
  localparam logic [8:0] P_CANCEL  = 9'b0_0010_0000;
  localparam logic [8:0] P_FIFTY   = 9'b0_0001_0000;
  localparam logic [8:0] P_TWENTY  = 9'b0_0000_1000;
  localparam logic [8:0] P_TEN     = 9'b0_0000_0100;
  localparam logic [8:0] P_FIVE    = 9'b0_0000_0010;
  localparam logic [8:0] P_ONE     = 9'b0_0000_0001;

  logic       clk;
  logic       rst_n;
  logic       goods, confirm, change, cancel;
  logic       m_one, m_five, m_ten, m_twenty, m_fifty;
  logic [2:0] sw_high, sw_low;
  logic [1:0] sw_num;
  logic [7:0] bit_sel, seg_sel;

  int checks = 0;
  int errors = 0;
  int frame [8];
  logic [7:0] seen;

  vending_state_transitions #(.SCAN_DIV(SCAN)) dut (
    .sys_clk        (clk),
    .sys_rst_n      (rst_n),
    .sys_Goods      (goods),
    .sys_Confirm    (confirm),
    .sys_Change     (change),
    .sys_Cancel     (cancel),
    .in_money_one   (m_one),
    .in_money_five  (m_five),
    .in_money_ten   (m_ten),
    .in_money_twenty(m_twenty),
    .in_money_fifty (m_fifty),
    .type_SW_high   (sw_high),
    .type_SW_low    (sw_low),
    .num_SW         (sw_num),
    .Bit_select     (bit_sel),
    .Seg_select     (seg_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Segment pattern to value: 0..9, 10 dash, 11 blank, 99 unknown
  function automatic int seg2val(input logic [7:0] s);
    case (s)
      8'hC0: return 0;
      8'hF9: return 1;
      8'hA4: return 2;
      8'hB0: return 3;
      8'h99: return 4;
      8'h92: return 5;
      8'h82: return 6;
      8'hF8: return 7;
      8'h80: return 8;
      8'h90: return 9;
      8'hBF: return 10;
      8'hFF: return 11;
      default: return 99;
    endcase
  endfunction

  task automatic press(input logic [8:0] m);
    @(negedge clk);
    {goods, confirm, change, cancel, m_fifty, m_twenty, m_ten, m_five, m_one} = m;
    repeat (3) @(negedge clk);
    {goods, confirm, change, cancel, m_fifty, m_twenty, m_ten, m_five, m_one} = '0;
    repeat (3) @(negedge clk);
  endtask

  // Watch one full scan and record the value shown on every digit
  task automatic capture(input string tag);
    for (int i = 0; i < 8; i++) frame[i] = 99;
    seen = '0;
    repeat (8 * SCAN + 4) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        if (bit_sel == ~(8'd1 << i)) begin
          frame[i] = seg2val(seg_sel);
          seen[i]  = 1'b1;
        end
      end
    end
    check({tag, "_digits_seen"}, int'(seen), 255);
  endtask

  function automatic int lo3();
    return frame[2] * 100 + frame[1] * 10 + frame[0];
  endfunction

  function automatic int hi3();
    return frame[5] * 100 + frame[4] * 10 + frame[3];
  endfunction

  task automatic expect_idle(input string tag);
    capture(tag);
    check({tag, "_state"}, frame[7], 0);
    check({tag, "_blank6"}, frame[6], 11);
    for (int i = 0; i < 6; i++) check({tag, "_dash"}, frame[i], 10);
  endtask

  task automatic expect_pay(input string tag, input int total, input int paid);
    capture(tag);
    check({tag, "_state"}, frame[7], 2);
    check({tag, "_total"}, hi3(), total);
    check({tag, "_paid"}, lo3(), paid);
  endtask

  task automatic expect_change(input string tag, input int note, input int rem);
    capture(tag);
    check({tag, "_state"}, frame[7], 3);
    check({tag, "_note"}, hi3(), note);
    check({tag, "_rem"}, lo3(), rem);
  endtask

  task automatic expect_select(input string tag, input int h, input int l,
                               input int q, input int total);
    capture(tag);
    check({tag, "_state"}, frame[7], 1);
    check({tag, "_high"}, frame[5], h);
    check({tag, "_low"}, frame[4], l);
    check({tag, "_qty"}, frame[3], q);
    check({tag, "_total"}, lo3(), total);
  endtask

  initial begin
    rst_n = 1'b0;
    {goods, confirm, change, cancel, m_fifty, m_twenty, m_ten, m_five, m_one} = '0;
    sw_high = 3'd0;
    sw_low  = 3'd0;
    sw_num  = 2'd0;

    // Reset and blank display before the first scan wrap
    #50;
    check("rst_bit_sel", int'(bit_sel), 255);
    check("rst_seg_sel", int'(seg_sel), 255);
    #50;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("prewrap_bit_sel", int'(bit_sel), 255);
    check("prewrap_seg_sel", int'(seg_sel), 255);
    expect_idle("idle0");

    // Confirm is ignored in IDLE, Goods enters SELECT
    press(P_CONFIRM);
    expect_idle("idle_confirm");
    sw_high = 3'd2; sw_low = 3'd1; sw_num = 2'd3;
    press(P_GOODS);
    expect_select("sel63", 2, 1, 3, 63);
    sw_high = 3'd3; sw_low = 3'd3; sw_num = 2'd1;
    repeat (3) @(negedge clk);
    expect_select("sel33", 3, 3, 1, 33);

    // Pay 36 in single notes, confirm, dispense 3 x 1
    press(P_CONFIRM);
    expect_pay("pay0", 33, 0);
    press(P_ONE);    expect_pay("pay1", 33, 1);
    press(P_FIVE);   expect_pay("pay6", 33, 6);
    press(P_TEN);    expect_pay("pay16", 33, 16);
    press(P_TWENTY); expect_pay("pay36", 33, 36);
    press(P_CONFIRM);
    expect_change("chg3", 0, 3);
    press(P_CHANGE); expect_change("chg2", 1, 2);
    press(P_CHANGE); expect_change("chg1", 1, 1);
    press(P_CHANGE); expect_idle("chg_done");
    press(P_CHANGE); expect_idle("chg_extra");

    // Pay 86, cancel, full refund in descending notes
    press(P_GOODS);
    expect_select("b_sel", 3, 3, 1, 33);
    press(P_CONFIRM);
    press(P_ONE); press(P_FIVE); press(P_TEN); press(P_TWENTY);
    press(P_FIFTY);
    expect_pay("b_pay86", 33, 86);
    press(P_CANCEL);
    expect_change("b_ref", 0, 86);
    press(P_CHANGE); expect_change("b_n50", 50, 36);
    press(P_CHANGE); expect_change("b_n20", 20, 16);
    press(P_CHANGE); expect_change("b_n10", 10, 6);
    press(P_CHANGE); expect_change("b_n5", 5, 1);
    press(P_CHANGE); expect_idle("b_done");

    // Same-cycle money is summed; Cancel beats Confirm; CHANGE ignores money
    press(P_GOODS);
    press(P_CONFIRM);
    press(P_FIFTY | P_TWENTY);
    expect_pay("c_pay70", 33, 70);
    press(P_CONFIRM | P_CANCEL);
    expect_change("c_ref", 0, 70);
    press(P_CHANGE); expect_change("c_n50", 50, 20);
    press(P_FIFTY | P_CONFIRM | P_CANCEL);
    expect_change("c_ignore", 50, 20);
    press(P_CHANGE); expect_idle("c_done");

    // Cancel in SELECT, zero total blocks confirm
    sw_high = 3'd0; sw_low = 3'd0; sw_num = 2'd0;
    press(P_GOODS);
    press(P_CANCEL);
    expect_idle("d_sel_cancel");
    press(P_GOODS);
    press(P_CONFIRM);
    expect_select("d_zero", 0, 0, 0, 0);
    sw_low = 3'd1; sw_num = 2'd1;
    press(P_CONFIRM);
    expect_pay("d_pay0", 1, 0);
    press(P_CONFIRM);
    expect_pay("d_short", 1, 0);

    // Overflow rejection at 230 + 50
    press(P_FIFTY); press(P_FIFTY); press(P_FIFTY); press(P_FIFTY);
    press(P_TWENTY); press(P_TEN);
    expect_pay("d_pay230", 1, 230);
    press(P_FIFTY);
    expect_pay("d_ovf", 1, 230);
    press(P_CANCEL);
    press(P_CHANGE);
    expect_change("d_n50", 50, 180);

    // Asynchronous reset mid-CHANGE
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_bit_sel", int'(bit_sel), 255);
    check("arst_seg_sel", int'(seg_sel), 255);
    #40;
    @(negedge clk);
    rst_n = 1'b1;
    expect_idle("arst_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
